// File: rtl/dvi_tmds_encoder.sv
// dvi_tmds_encoder: three-channel DVI TMDS encoder (blue/green/red -> ch 0/1/2).
// Pipeline: input register -> transition-minimised q_m register -> symbol and
// running-disparity register, so symbols appear two edges after sampling.
// Optional macro DVI_TMDS_ENC_REG_OUT_EN adds one more output register stage
// (latency 3) ahead of the serialiser; encoding is identical in both builds.
module dvi_tmds_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       rgb_in_vsync,
  input  logic       rgb_in_hsync,
  input  logic       rgb_in_de,
  input  logic [7:0] rgb_in_data_b,
  input  logic [7:0] rgb_in_data_g,
  input  logic [7:0] rgb_in_data_r,
  output logic [9:0] tmds_data_0,
  output logic [9:0] tmds_data_1,
  output logic [9:0] tmds_data_2,
  output logic       tmds_de
);

  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // XOR or XNOR chaining, whichever yields fewer transitions; bit 8 flags XOR.
  function automatic logic [8:0] min_trans(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  logic de_s1_q, de_s2_q, de_s3_q;

  // de travels alongside the channel data through all three stages
  always_ff @(posedge clk) begin
    if (reset) begin
      de_s1_q <= 1'b0;
      de_s2_q <= 1'b0;
      de_s3_q <= 1'b0;
    end else begin
      de_s1_q <= rgb_in_de;
      de_s2_q <= de_s1_q;
      de_s3_q <= de_s2_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [7:0]        data_in;
      logic [1:0]        ctrl_in;
      logic [7:0]        data_s1_q;
      logic [1:0]        ctrl_s1_q, ctrl_s2_q;
      logic [8:0]        qm_s2_q;
      logic [9:0]        sym_q, sym_d;
      logic signed [4:0] cnt_q, cnt_d;
      logic signed [5:0] diff, cnt_ext, cnt_sum;

      // Only channel 0 carries sync; the others always send C = 00.
      assign data_in = (gi == 0) ? rgb_in_data_b : ((gi == 1) ? rgb_in_data_g : rgb_in_data_r);
      assign ctrl_in = (gi == 0) ? {rgb_in_vsync, rgb_in_hsync} : 2'b00;

      // Stage 1 samples the inputs; stage 2 holds the transition-minimised word
      always_ff @(posedge clk) begin
        if (reset) begin
          data_s1_q <= '0;
          ctrl_s1_q <= 2'b00;
          ctrl_s2_q <= 2'b00;
          qm_s2_q   <= '0;
        end else begin
          data_s1_q <= data_in;
          ctrl_s1_q <= ctrl_in;
          ctrl_s2_q <= ctrl_s1_q;
          qm_s2_q   <= min_trans(data_s1_q);
        end
      end

      // DC-balance decision on q_m, or control symbol (and disparity clear) in blanking
      always_comb begin
        diff    = $signed({1'b0, ones8(qm_s2_q[7:0]), 1'b0}) - 6'sd8;  // N1 - N0
        cnt_ext = {cnt_q[4], cnt_q};
        cnt_sum = cnt_ext;
        sym_d   = CTRL_00;
        if (!de_s2_q) begin
          unique case (ctrl_s2_q)
            2'b01:   sym_d = CTRL_01;
            2'b10:   sym_d = CTRL_10;
            2'b11:   sym_d = CTRL_11;
            default: sym_d = CTRL_00;
          endcase
          cnt_sum = '0;
        end else if ((cnt_q == 5'sd0) || (diff == 6'sd0)) begin
          sym_d   = {~qm_s2_q[8], qm_s2_q[8], qm_s2_q[8] ? qm_s2_q[7:0] : ~qm_s2_q[7:0]};
          cnt_sum = qm_s2_q[8] ? (cnt_ext + diff) : (cnt_ext - diff);
        end else if ((!cnt_q[4] && (diff > 6'sd0)) || (cnt_q[4] && (diff < 6'sd0))) begin
          sym_d   = {1'b1, qm_s2_q[8], ~qm_s2_q[7:0]};
          cnt_sum = cnt_ext + (qm_s2_q[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
          sym_d   = {1'b0, qm_s2_q[8], qm_s2_q[7:0]};
          cnt_sum = cnt_ext - (qm_s2_q[8] ? 6'sd0 : 6'sd2) + diff;
        end
        cnt_d = cnt_sum[4:0];
      end

      // Stage 3 registers the symbol and the running disparity
      always_ff @(posedge clk) begin
        if (reset) begin
          sym_q <= CTRL_00;
          cnt_q <= 5'sd0;
        end else begin
          sym_q <= sym_d;
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

`ifdef DVI_TMDS_ENC_REG_OUT_EN
  logic [9:0] out0_q, out1_q, out2_q;
  logic       de_out_q;

  // Extra retiming stage ahead of the serialiser
  always_ff @(posedge clk) begin
    if (reset) begin
      out0_q   <= CTRL_00;
      out1_q   <= CTRL_00;
      out2_q   <= CTRL_00;
      de_out_q <= 1'b0;
    end else begin
      out0_q   <= g_ch[0].sym_q;
      out1_q   <= g_ch[1].sym_q;
      out2_q   <= g_ch[2].sym_q;
      de_out_q <= de_s3_q;
    end
  end

  assign tmds_data_0 = out0_q;
  assign tmds_data_1 = out1_q;
  assign tmds_data_2 = out2_q;
  assign tmds_de     = de_out_q;
`else
  assign tmds_data_0 = g_ch[0].sym_q;
  assign tmds_data_1 = g_ch[1].sym_q;
  assign tmds_data_2 = g_ch[2].sym_q;
  assign tmds_de     = de_s3_q;
`endif

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// tb_dvi_tmds_encoder: directed vectors with hand-computed TMDS symbols, then a
// random soak checked by decoding each symbol and tracking the running disparity.
`timescale 1ns/1ps
module tb_dvi_tmds_encoder;

`ifdef DVI_TMDS_ENC_REG_OUT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rgb_in_vsync = 1'b0, rgb_in_hsync = 1'b0, rgb_in_de = 1'b0;
  logic [7:0] rgb_in_data_b = '0, rgb_in_data_g = '0, rgb_in_data_r = '0;
  logic [9:0] tmds_data_0, tmds_data_1, tmds_data_2;
  logic       tmds_de;

  dvi_tmds_encoder dut (
    .clk           (clk),
    .reset         (reset),
    .rgb_in_vsync  (rgb_in_vsync),
    .rgb_in_hsync  (rgb_in_hsync),
    .rgb_in_de     (rgb_in_de),
    .rgb_in_data_b (rgb_in_data_b),
    .rgb_in_data_g (rgb_in_data_g),
    .rgb_in_data_r (rgb_in_data_r),
    .tmds_data_0   (tmds_data_0),
    .tmds_data_1   (tmds_data_1),
    .tmds_data_2   (tmds_data_2),
    .tmds_de       (tmds_de)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            exact;   // 1: compare against e; 0: decode-based check
    logic [2:0][9:0] e;
    logic            de;
    logic [1:0]      c;
    logic [2:0][7:0] d;
    logic [15:0]     id;
  } exp_t;

  exp_t pipe[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_id = 0;
  int   disp[3] = '{0, 0, 0};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ones10(input logic [9:0] v);
    int n = 0;
    for (int i = 0; i < 10; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      2'b11:   return 10'h2AB;
      default: return 10'h354;
    endcase
  endfunction

  task automatic check_entry(input exp_t x);
    logic [9:0] sym;
    logic [7:0] qm, dec, dat;
    int         n1d, n1q;
    logic       use_xnor, exp9;
    for (int ch = 0; ch < 3; ch++) begin
      sym = (ch == 0) ? tmds_data_0 : ((ch == 1) ? tmds_data_1 : tmds_data_2);
      dat = x.d[ch];
      if (x.exact) begin
        check_eq($sformatf("v%0d_ch%0d_sym", x.id, ch), {22'b0, sym}, {22'b0, x.e[ch]});
      end else if (!x.de) begin
        check_eq($sformatf("v%0d_ch%0d_ctrl", x.id, ch), {22'b0, sym},
                 {22'b0, ctrl_sym((ch == 0) ? x.c : 2'b00)});
      end else begin
        qm     = sym[9] ? ~sym[7:0] : sym[7:0];
        dec[0] = qm[0];
        for (int i = 1; i < 8; i++) dec[i] = sym[8] ? (qm[i] ^ qm[i-1]) : ~(qm[i] ^ qm[i-1]);
        check_eq($sformatf("v%0d_ch%0d_decode", x.id, ch), {24'b0, dec}, {24'b0, dat});
        n1d      = ones10({2'b00, dat});
        use_xnor = (n1d > 4) || ((n1d == 4) && !dat[0]);
        check_eq($sformatf("v%0d_ch%0d_bit8", x.id, ch), {31'b0, sym[8]}, {31'b0, ~use_xnor});
        n1q = ones10({2'b00, qm});
        if (disp[ch] == 0 || n1q == 4)                              exp9 = ~sym[8];
        else if ((disp[ch] > 0 && n1q > 4) || (disp[ch] < 0 && n1q < 4)) exp9 = 1'b1;
        else                                                        exp9 = 1'b0;
        check_eq($sformatf("v%0d_ch%0d_bit9", x.id, ch), {31'b0, sym[9]}, {31'b0, exp9});
      end
      if (!x.de) disp[ch] = 0;
      else       disp[ch] += 2 * ones10(sym) - 10;
    end
    check_eq($sformatf("v%0d_de", x.id), {31'b0, tmds_de}, {31'b0, x.de});
  endtask

  // One pixel clock: check the symbol due now, then drive the next input.
  task automatic cycle(input logic de, input logic [1:0] c, input logic [7:0] b, g, r,
                       input logic exact, input logic [9:0] e0, e1, e2);
    exp_t x;
    @(negedge clk);
    if (pipe.size() == LAT + 1) check_entry(pipe.pop_front());
    reset         = 1'b0;
    rgb_in_de     = de;
    rgb_in_vsync  = c[1];
    rgb_in_hsync  = c[0];
    rgb_in_data_b = b;
    rgb_in_data_g = g;
    rgb_in_data_r = r;
    x.exact = exact;
    x.e     = {e2, e1, e0};
    x.de    = de;
    x.c     = c;
    x.d     = {r, g, b};
    x.id    = 16'(vec_id);
    vec_id++;
    pipe.push_back(x);
  endtask

  task automatic px(input logic [7:0] b, g, r, input logic [9:0] e0, e1, e2);
    cycle(1'b1, 2'b00, b, g, r, 1'b1, e0, e1, e2);
  endtask

  task automatic ctl(input logic [1:0] c, input logic [9:0] e0);
    cycle(1'b0, c, 8'h00, 8'h00, 8'h00, 1'b1, e0, 10'h354, 10'h354);
  endtask

  task automatic rand_inputs();
    rgb_in_de     = 1'($urandom);
    rgb_in_vsync  = 1'($urandom);
    rgb_in_hsync  = 1'($urandom);
    rgb_in_data_b = 8'($urandom);
    rgb_in_data_g = 8'($urandom);
    rgb_in_data_r = 8'($urandom);
  endtask

  // Hold reset n cycles checking the idle symbol every cycle, then expect idle
  // symbols until the first post-release input has propagated.
  task automatic do_reset(input int n);
    exp_t x;
    pipe.delete();
    @(negedge clk);
    reset = 1'b1;
    rand_inputs();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("rst_ch0", {22'b0, tmds_data_0}, 32'h354);
      check_eq("rst_ch1", {22'b0, tmds_data_1}, 32'h354);
      check_eq("rst_ch2", {22'b0, tmds_data_2}, 32'h354);
      check_eq("rst_de", {31'b0, tmds_de}, 32'h0);
      rand_inputs();
    end
    x.exact = 1'b1;
    x.e     = {10'h354, 10'h354, 10'h354};
    x.de    = 1'b0;
    x.c     = 2'b00;
    x.d     = '0;
    x.id    = 16'hFFFF;
    for (int i = 0; i <= LAT; i++) pipe.push_back(x);
  endtask

  logic cur_de;

  initial begin
    do_reset(3);

    // control symbols on channel 0
    ctl(2'b01, 10'h0AB);
    ctl(2'b10, 10'h154);
    ctl(2'b11, 10'h2AB);
    ctl(2'b00, 10'h354);

    // zero pixels from cnt 0: -8, +2, -6
    px(8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100);
    px(8'h00, 8'h00, 8'h00, 10'h3FF, 10'h3FF, 10'h3FF);
    px(8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100);
    ctl(2'b00, 10'h354);

    // full scale: XNOR path, cnt -8, then case C to cnt -2
    px(8'hFF, 8'hFF, 8'hFF, 10'h200, 10'h200, 10'h200);
    px(8'hFF, 8'hFF, 8'hFF, 10'h0FF, 10'h0FF, 10'h0FF);
    ctl(2'b01, 10'h0AB);

    // balanced 0x55 keeps cnt at 0; channels carry different colours
    px(8'h55, 8'h00, 8'hFF, 10'h133, 10'h100, 10'h200);
    ctl(2'b00, 10'h354);

    // disparity cleared by a single blanking cycle
    px(8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100);
    px(8'h00, 8'h00, 8'h00, 10'h3FF, 10'h3FF, 10'h3FF);
    ctl(2'b00, 10'h354);
    px(8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100);
    px(8'h00, 8'h00, 8'h00, 10'h3FF, 10'h3FF, 10'h3FF);

    // reset mid-line, then the first pixel restarts from cnt 0
    px(8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100);
    px(8'h00, 8'h00, 8'h00, 10'h3FF, 10'h3FF, 10'h3FF);
    do_reset(2);
    px(8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100);
    px(8'h00, 8'h00, 8'h00, 10'h3FF, 10'h3FF, 10'h3FF);

    // random soak: decode, XOR/XNOR choice and disparity-driven inversion
    cur_de = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) cur_de = ~cur_de;
      cycle(cur_de, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
            1'b0, 10'h000, 10'h000, 10'h000);
    end

    // drain the pipeline
    for (int i = 0; i <= LAT; i++) ctl(2'b00, 10'h354);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
